// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage radix-2 restoring divider.
// State encodings, handshake levels and reset polarity.
package div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX <-> divider request/result bundle.
// The master is EX; the slave is the divider.
interface div_if
  import div_pkg::*;
#(
  parameter int DW = DATA_W
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;
  logic            stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i,
    output start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i,
    input  start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Stalls the pipeline while busy; returns {rem, quo}.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = div_pkg::DATA_W,
  parameter int CNT_W  = div_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_e state, state_n;

  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [2*DATA_W:0]   dvd, dvd_n;
  logic [DATA_W-1:0]   dvs, dvs_n;
  logic                negq, negq_n;
  logic                negr, negr_n;
  logic [2*DATA_W-1:0] result, result_n;
  logic                ready, ready_n;

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W-1:0]   quo, rem;

  assign bus.result_o   = result;
  assign bus.ready_o    = ready;
  assign bus.stallreq_o = bus.start_i & ~ready;

  assign diff = {1'b0, dvd[2*DATA_W-1:DATA_W]}
              - {1'b0, dvs};

  assign mag1 = (bus.signed_div_i & bus.opdata1_i[DATA_W-1])
              ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i & bus.opdata2_i[DATA_W-1])
              ? -bus.opdata2_i : bus.opdata2_i;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dvd_n    = dvd;
    dvs_n    = dvs;
    negq_n   = negq;
    negr_n   = negr;
    result_n = result;
    ready_n  = ready;
    quo      = dvd[DATA_W-1:0];
    rem      = dvd[2*DATA_W:DATA_W+1];
    unique case (state)
      DivFree: begin
        ready_n  = DivResultNotReady;
        result_n = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_n = DivByZero;
          end else begin
            state_n = DivOn;
            cnt_n   = '0;
            dvd_n   = {{DATA_W{1'b0}}, mag1, 1'b0};
            dvs_n   = mag2;
            negq_n  = bus.signed_div_i
                    & (bus.opdata1_i[DATA_W-1]
                    ^  bus.opdata2_i[DATA_W-1]);
            negr_n  = bus.signed_div_i
                    & bus.opdata1_i[DATA_W-1];
          end
        end
      end
      DivByZero: begin
        dvd_n   = '0;
        state_n = DivEnd;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_n = DivFree;
        end else if (cnt != CNT_W'(DATA_W)) begin
          // borrow means the trial subtract failed: restore
          if (diff[DATA_W])
            dvd_n = {dvd[2*DATA_W-1:0], 1'b0};
          else
            dvd_n = {diff[DATA_W-1:0],
                     dvd[DATA_W-1:0], 1'b1};
          cnt_n = cnt + 1'b1;
        end else begin
          if (negq) quo = -quo;
          if (negr) rem = -rem;
          dvd_n   = {rem, dvd[DATA_W], quo};
          state_n = DivEnd;
          cnt_n   = '0;
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStart) begin
          ready_n  = DivResultReady;
          result_n = {dvd[2*DATA_W:DATA_W+1],
                      dvd[DATA_W-1:0]};
        end else begin
          state_n  = DivFree;
          ready_n  = DivResultNotReady;
          result_n = '0;
        end
      end
      default: state_n = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state  <= DivFree;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      negq   <= 1'b0;
      negr   <= 1'b0;
      result <= '0;
      ready  <= DivResultNotReady;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dvd    <= dvd_n;
      dvs    <= dvs_n;
      negq   <= negq_n;
      negr   <= negr_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the EX stage, serving DIV/DIVU.
- It is the requesting end of the pipeline stall interface. While a division is in progress it raises stallreq_o toward the pipeline controller.
- The controller turns that request into the stall vector that freezes the IF/ID and ID/EX stage registers.
- The final {remainder, quotient} is returned to EX for the HI/LO write.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width (must hold DATA_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset (RstEnable = 1)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request from EX; held high until ready_o is seen
- annul_i  in  1  cancel the current division (branch flush or exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid
- stallreq_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset: on the first edge with rst=1:
  - state = DivFree
  - result_o = 0, ready_o = 0
  - counter = 0, internal 65-bit dividend register = 0
  - The reset takes effect from any state, including mid-division. No partial result is ever exposed.
- stallreq_o is combinational: start_i & ~ready_o. It is deasserted in the same cycle ready_o rises.
- DivFree:
  - start_i=1 and annul_i=0 with divisor 0 → DivByZero.
  - start_i=1 and annul_i=0 with divisor nonzero → DivOn, counter = 0.
  - On entry to DivOn, operands are latched as magnitudes: when signed_div_i=1 and the sign bit is set, the two's complement is taken.
  - The dividend register is loaded with {32'b0, |op1|, 1'b0}.
  - Otherwise stay in DivFree with ready_o = 0 and result_o = 0.
- DivByZero: clear the dividend register → DivEnd on the next edge. Result = 0.
- DivOn, annul_i=1: go to DivFree on the same edge and discard all work.
- DivOn, counter < 32: one iteration per cycle, then counter++.
  - diff = dividend[63:32] − |divisor|, computed at 33 bits.
  - If the borrow is set: dividend <= {dividend[63:0], 1'b0}.
  - Else: dividend <= {diff[31:0], dividend[31:0], 1'b1}.
- DivOn, counter == 32: apply sign correction, then go to DivEnd with ready_o = 1 and result_o = {rem, quo}.
  - quo is negated when signed and op1[31]^op2[31].
  - rem is negated when signed and op1[31]; the remainder takes the dividend's sign.
- DivEnd: hold result_o and ready_o while start_i=1. When start_i=0: go to DivFree, ready_o = 0, result_o = 0.
- Latency, taking edge 0 as the edge that samples start_i:
  - Nonzero divisor: ready_o is high after edge 34.
  - Divide by zero: ready_o is high after edge 2.
- Operands must stay stable while start_i=1. The divider uses its latched copies, so later changes are ignored.
- annul_i is ignored in DivByZero and DivEnd. EX drops start_i on flush, which returns the block to DivFree.
- Overflow case 0x80000000 / −1 (signed): quotient 0x80000000, remainder 0. No trap is raised.

Decomposition:
- Shared defines file:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2 bits)
  - DivStart/DivStop, DivResultReady/DivResultNotReady
  - existing RstEnable, ZeroWord
- No sub-module. The iteration step (subtract and shift) stays inline.

Test Plan:
- Unsigned 100 ÷ 7 (start held) → ready_o after edge 34; result_o = {0x0000_0002, 0x0000_000E}. stallreq_o high on edges 0–33, low once ready_o is high.
- Signed −100 ÷ 7 → quotient 0xFFFF_FFF2, remainder 0xFFFF_FFFE. Signed 0x8000_0000 ÷ 0xFFFF_FFFF → {0, 0x8000_0000}.
- Divisor 0 (either mode) → ready_o after edge 2, result_o = 0. start_i then dropped → ready_o = 0 next edge.
- annul_i pulsed at edge 10 of a division → state returns to DivFree; ready_o never rises. A new start (0xFFFF_FFFF ÷ 0x10, unsigned) then completes with {0xF, 0x0FFF_FFFF}.
- rst asserted at edge 20 of a division → all outputs 0 on the next edge, state DivFree. A subsequent division completes correctly.
- start_i held for 5 cycles after ready_o → result_o and ready_o stable throughout. Deassert → cleared on the next edge.
